// File: rtl/hdmi_link_ctrl.sv
// HDMI/DVI link bring-up sequencer: qualifies PLL lock, hot-plug and enable,
// then steps OFF -> WAIT_LOCK -> SETTLE (control tokens) -> ACTIVE (pass-through).
module hdmi_link_ctrl #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int HPD_DEBOUNCE  = 16,
  parameter int LOCK_FILTER   = 8
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        pll_lock,
  input  logic        hpd,
  input  logic        enable,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [29:0] tmds_in,
  output logic [29:0] tmds_out,
  output logic        serdes_reset,
  output logic        link_active,
  output logic [1:0]  state,
  output logic [7:0]  relink_count
);

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  localparam int LOCK_W   = $clog2(LOCK_FILTER   > 1 ? LOCK_FILTER   : 2);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES > 1 ? SETTLE_CYCLES : 2);
  localparam int DEB_W    = $clog2(HPD_DEBOUNCE  > 1 ? HPD_DEBOUNCE  : 2);

  localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0]    DEB_MAX    = DEB_W'(HPD_DEBOUNCE - 1);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    ACTIVE    = 2'd3
  } state_t;

  function automatic logic [9:0] ctl_token(input logic [1:0] vh);
    case (vh)
      2'b00:   ctl_token = T00;
      2'b01:   ctl_token = T01;
      2'b10:   ctl_token = T10;
      default: ctl_token = T11;
    endcase
  endfunction

  logic lock_meta, lock_s, hpd_meta, hpd_s, hpd_ok, go;
  logic [DEB_W-1:0] deb_cnt;

  // 2-flop synchronisers followed by a level debounce on hpd.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      hpd_meta  <= 1'b0;
      hpd_s     <= 1'b0;
      hpd_ok    <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      hpd_meta  <= hpd;
      hpd_s     <= hpd_meta;
      if (hpd_s != hpd_ok) begin
        if (deb_cnt == DEB_MAX) begin
          hpd_ok  <= hpd_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign go = enable & hpd_ok;

  state_t                cur, nxt;
  logic [LOCK_W-1:0]     lock_cnt, lock_nxt;
  logic [SETTLE_W-1:0]   settle_cnt, settle_nxt;
  logic [7:0]            relink_nxt;
  logic [29:0]           tmds_nxt;
  logic                  sr_nxt, la_nxt;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cur          <= OFF;
      lock_cnt     <= '0;
      settle_cnt   <= '0;
      relink_count <= 8'd0;
      tmds_out     <= {3{T00}};
      serdes_reset <= 1'b1;
      link_active  <= 1'b0;
    end else begin
      cur          <= nxt;
      lock_cnt     <= lock_nxt;
      settle_cnt   <= settle_nxt;
      relink_count <= relink_nxt;
      tmds_out     <= tmds_nxt;
      serdes_reset <= sr_nxt;
      link_active  <= la_nxt;
    end
  end

  // !go has priority over lock loss, which has priority over progress.
  always_comb begin
    nxt        = cur;
    lock_nxt   = lock_cnt;
    settle_nxt = settle_cnt;
    relink_nxt = relink_count;
    case (cur)
      OFF: begin
        if (go) begin
          nxt      = WAIT_LOCK;
          lock_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        if (!go) begin
          nxt = OFF;
        end else if (!lock_s) begin
          lock_nxt = '0;
        end else if (lock_cnt == LOCK_MAX) begin
          nxt        = SETTLE;
          settle_nxt = '0;
        end else begin
          lock_nxt = lock_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (!go) begin
          nxt = OFF;
        end else if (!lock_s) begin
          nxt      = WAIT_LOCK;
          lock_nxt = '0;
        end else if (settle_cnt == SETTLE_MAX) begin
          nxt = ACTIVE;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      default: begin
        if (!go || !lock_s) begin
          nxt      = go ? WAIT_LOCK : OFF;
          lock_nxt = '0;
          if (relink_count != 8'hFF) relink_nxt = relink_count + 1'b1;
        end
      end
    endcase

    // Outputs are keyed off the next state so they line up with state.
    tmds_nxt = {3{T00}};
    sr_nxt   = 1'b1;
    la_nxt   = 1'b0;
    case (nxt)
      SETTLE: begin
        sr_nxt   = 1'b0;
        tmds_nxt = {T00, T00, ctl_token({vsync, hsync})};
      end
      ACTIVE: begin
        sr_nxt   = 1'b0;
        la_nxt   = 1'b1;
        tmds_nxt = tmds_in;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule
